// File: rtl/mole_button_conditioner.sv
// mole_button_conditioner
// Input stage for the whack-a-mole game core. Each raw push button is
// synchronised to cin through two flops and then debounced. A level change
// is accepted only after the synchronised input has differed from the
// accepted level for DEBOUNCE_CYCLES consecutive cycles. Each accepted
// press produces a one-cycle strobe and an encoded hit index.
//
// Optional feature: define BTN_LOCKOUT_EN to enable press-report lockout.
// After any reported press, further reports are suppressed for
// LOCKOUT_CYCLES cycles. btn_level keeps updating while reports are
// suppressed. Presses accepted during lockout are dropped, not queued.
//
// Ports:
//   cin         - system clock (50 MHz)
//   reset       - asynchronous, active-high reset
//   btn_raw     - raw button pins, asynchronous to cin
//   btn_level   - debounced level per button, 1 = pressed
//   press_pulse - one-cycle strobe per button when a press is accepted
//   press_valid - one-cycle strobe: at least one press_pulse bit is set
//   press_idx   - lowest-numbered button in press_pulse (0 when idle)
//   press_multi - one-cycle strobe: more than one press_pulse bit is set
module mole_button_conditioner #(
  parameter int N_BTN           = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 0,
  parameter int LOCKOUT_CYCLES  = 25000000
) (
  input  logic             cin,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic             press_valid,
  output logic [3:0]       press_idx,
  output logic             press_multi
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] POL    = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  // Lowest set bit wins, so scan from the top and let lower bits overwrite.
  function automatic logic [3:0] lowest_idx(input logic [N_BTN-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [N_BTN-1:0] v);
    return (v & (v - N_BTN'(1))) != {N_BTN{1'b0}};
  endfunction

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] s_s;
  logic [CNT_W-1:0] cnt_r      [N_BTN];
  logic [CNT_W-1:0] cnt_next_s [N_BTN];
  logic [N_BTN-1:0] level_next_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] rpt_s;

  assign s_s    = sync2_r ^ POL;
  assign rise_s = level_next_s & ~btn_level;

  // Per-channel debounce next state: clear when stable, count while different,
  // toggle the accepted level on the last counted cycle.
  always_comb begin
    level_next_s = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_next_s[i] = {CNT_W{1'b0}};
      if (s_s[i] == btn_level[i]) begin
        cnt_next_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == DB_MAX) begin
        cnt_next_s[i]   = {CNT_W{1'b0}};
        level_next_s[i] = ~btn_level[i];
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

`ifdef BTN_LOCKOUT_EN
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic [LOCK_W-1:0] lock_cnt_r;
  logic              report_ok_s;

  assign report_ok_s = (lock_cnt_r == {LOCK_W{1'b0}});
  assign rpt_s       = report_ok_s ? rise_s : {N_BTN{1'b0}};

  // Lockout timer: reload on every reported press, then count down to zero.
  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
    end else if (rpt_s != {N_BTN{1'b0}}) begin
      lock_cnt_r <= LOCK_MAX;
    end else if (!report_ok_s) begin
      lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
    end else begin
      lock_cnt_r <= lock_cnt_r;
    end
  end
`else
  assign rpt_s = rise_s;
`endif

  // Synchroniser, debounce state and registered press reporting.
  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      sync1_r     <= {N_BTN{1'b0}};
      sync2_r     <= {N_BTN{1'b0}};
      btn_level   <= {N_BTN{1'b0}};
      press_pulse <= {N_BTN{1'b0}};
      press_valid <= 1'b0;
      press_idx   <= 4'd0;
      press_multi <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r     <= btn_raw;
      sync2_r     <= sync1_r;
      btn_level   <= level_next_s;
      press_pulse <= rpt_s;
      press_valid <= (rpt_s != {N_BTN{1'b0}});
      press_idx   <= lowest_idx(rpt_s);
      press_multi <= more_than_one(rpt_s);
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

endmodule

// File: tb/tb_mole_button_conditioner.sv
// Testbench for mole_button_conditioner with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected press report (pulse, idx, multi, arrival cycle)
// into a scoreboard queue; a monitor pops and compares whenever press_valid
// is seen, and checks that outputs are idle otherwise.
module tb_mole_button_conditioner;

  typedef struct {
    logic [8:0] pulse;
    logic [3:0] idx;
    logic       multi;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] btn_raw;
  logic [8:0] btn_level;
  logic [8:0] press_pulse;
  logic       press_valid;
  logic [3:0] press_idx;
  logic       press_multi;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  int   c1;
  exp_t sb[$];

  mole_button_conditioner #(
    .N_BTN(9), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(0), .LOCKOUT_CYCLES(20)
  ) dut (
    .cin(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .press_valid(press_valid),
    .press_idx(press_idx), .press_multi(press_multi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic push(input logic [8:0] p, input logic [3:0] i, input logic m, input int c);
    exp_t e;
    e.pulse = p; e.idx = i; e.multi = m; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_press: expected pulse %h at cycle %0d, none by cycle %0d",
                 sb[0].pulse, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (press_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_press: pulse %h idx %0d multi %b at cycle %0d",
                   press_pulse, press_idx, press_multi, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (press_pulse !== e.pulse || press_idx !== e.idx ||
              press_multi !== e.multi || cyc != e.cyc) begin
            errors++;
            $display("FAIL press_report: got pulse %h idx %0d multi %b cycle %0d, expected pulse %h idx %0d multi %b cycle %0d",
                     press_pulse, press_idx, press_multi, cyc, e.pulse, e.idx, e.multi, e.cyc);
          end
        end
      end else begin
        checks++;
        if (press_pulse !== 9'h000 || press_idx !== 4'd0 || press_multi !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: pulse %h idx %0d multi %b at cycle %0d",
                   press_pulse, press_idx, press_multi, cyc);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    btn_raw = 9'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_level", {7'd0, btn_level}, 16'h0000);
    chk("reset_report", {2'd0, press_pulse, press_valid, press_idx}, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) step();

    // Single press on button 3, held
    step(); btn_raw[3] = 1'b1; c0 = cyc;
    push(9'h008, 4'd3, 1'b0, c0 + 6);
    at_neg(c0 + 5); chk("b3_level_early", {7'd0, btn_level}, 16'h0000);
    at_neg(c0 + 6); chk("b3_level", {7'd0, btn_level}, 16'h0008);
    at_neg(c0 + 25); chk("b3_level_held", {7'd0, btn_level}, 16'h0008);
    step(); btn_raw[3] = 1'b0; c0 = cyc;
    at_neg(c0 + 5); chk("b3_rel_early", {7'd0, btn_level}, 16'h0008);
    at_neg(c0 + 6); chk("b3_rel", {7'd0, btn_level}, 16'h0000);
    repeat (30) step();

    // Bouncing button 0: 2 cycles high, 2 cycles low, 40 cycles
    for (int j = 0; j < 10; j++) begin
      step(); btn_raw[0] = 1'b1;
      step(); step(); btn_raw[0] = 1'b0;
      step();
    end
    at_neg(cyc + 2); chk("b0_bounce_level", {7'd0, btn_level}, 16'h0000);
    step(); btn_raw[0] = 1'b1; c0 = cyc;
    push(9'h001, 4'd0, 1'b0, c0 + 6);
    at_neg(c0 + 5); chk("b0_hold_early", {7'd0, btn_level}, 16'h0000);
    at_neg(c0 + 6); chk("b0_hold", {7'd0, btn_level}, 16'h0001);
    step(); btn_raw[0] = 1'b0;
    repeat (30) step();

    // Simultaneous press on buttons 2 and 5
    step(); btn_raw[2] = 1'b1; btn_raw[5] = 1'b1; c0 = cyc;
    push(9'h024, 4'd2, 1'b1, c0 + 6);
    at_neg(c0 + 6); chk("b25_level", {7'd0, btn_level}, 16'h0024);
    step(); btn_raw[2] = 1'b0; btn_raw[5] = 1'b0;
    repeat (30) step();

    // Button 7: press, release, re-press
    step(); btn_raw[7] = 1'b1; c0 = cyc;
    push(9'h080, 4'd7, 1'b0, c0 + 6);
    at_neg(c0 + 10);
    step(); btn_raw[7] = 1'b0; c0 = cyc;
    at_neg(c0 + 5); chk("b7_rel_early", {7'd0, btn_level}, 16'h0080);
    at_neg(c0 + 6); chk("b7_rel", {7'd0, btn_level}, 16'h0000);
    repeat (30) step();
    step(); btn_raw[7] = 1'b1; c0 = cyc;
    push(9'h080, 4'd7, 1'b0, c0 + 6);
    at_neg(c0 + 6); chk("b7_repress", {7'd0, btn_level}, 16'h0080);
    step(); btn_raw[7] = 1'b0;
    repeat (30) step();

    // Reset while button 1 is mid-count, button 8 already accepted
    step(); btn_raw[8] = 1'b1; c0 = cyc;
    push(9'h100, 4'd8, 1'b0, c0 + 6);
    at_neg(c0 + 8); chk("b8_level", {7'd0, btn_level}, 16'h0100);
    step(); btn_raw[1] = 1'b1; c0 = cyc;
    at_neg(c0 + 3);
    step();
    reset = 1'b1; btn_raw[8] = 1'b0;
    #1;
    chk("midreset_level", {7'd0, btn_level}, 16'h0000);
    chk("midreset_report", {2'd0, press_pulse, press_valid, press_idx}, 16'h0000);
    chk("midreset_multi", {15'd0, press_multi}, 16'h0000);
    repeat (3) step();
    reset = 1'b0; c0 = cyc;
    push(9'h002, 4'd1, 1'b0, c0 + 6);
    at_neg(c0 + 5); chk("b1_after_reset_early", {7'd0, btn_level}, 16'h0000);
    at_neg(c0 + 6); chk("b1_after_reset", {7'd0, btn_level}, 16'h0002);
    step(); btn_raw[1] = 1'b0;
    repeat (30) step();

`ifdef BTN_LOCKOUT_EN
    // Lockout: btn 6 press inside the window is dropped, later one reported
    step(); btn_raw[4] = 1'b1; c0 = cyc;
    push(9'h010, 4'd4, 1'b0, c0 + 6);
    at_neg(c0 + 9);
    step(); btn_raw[6] = 1'b1; c1 = cyc;
    at_neg(c1 + 6); chk("lock_level", {7'd0, btn_level}, 16'h0050);
    step(); btn_raw[6] = 1'b0;
    at_neg(c0 + 40);
    step(); btn_raw[6] = 1'b1; c1 = cyc;
    push(9'h040, 4'd6, 1'b0, c1 + 6);
    at_neg(c1 + 6); chk("post_lock_level", {7'd0, btn_level}, 16'h0050);
    step(); btn_raw[4] = 1'b0; btn_raw[6] = 1'b0;
    repeat (30) step();
`endif

    repeat (20) step();
    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_button_conditioner.md
Name: mole_button_conditioner

Overview:
- Upstream input stage for the whack-a-mole game core.
- Takes the 9 raw breadboard push buttons, synchronises each one to cin, and debounces it.
- Emits one-cycle press events plus an encoded hit index; the game FSM consumes these to score hits against the lit mole.
- Sits between the SW pins and the game/score logic.

Parameters:
N_BTN, 9, number of button channels (index width fixed at 4 bits, so N_BTN <= 15)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz)
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed (inverted after synchroniser)
LOCKOUT_CYCLES, 25000000, press-report lockout length (used only with LOCKOUT_EN)

Ports:
cin  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
btn_raw  input  N_BTN  raw button pins, asynchronous to cin
btn_level  output  N_BTN  debounced level per button, 1 = pressed
press_pulse  output  N_BTN  one-cycle strobe per button on accepted press (0->1 of btn_level)
press_valid  output  1  one-cycle strobe: at least one press_pulse bit set this cycle
press_idx  output  4  index of lowest-numbered button in press_pulse; 0 when press_valid=0
press_multi  output  1  one-cycle strobe: more than one press_pulse bit set this cycle

Behaviour:
- Reset (async assert, sync release) clears all synchroniser flops, counters, btn_level, press_pulse, press_valid, press_idx and press_multi to 0.
- Synchroniser: per channel, 2 flops; then invert if ACTIVE_LOW=1, giving s[i].
- Per-channel debounce state (two implicit states, STABLE and COUNTING):
  - s[i]==btn_level[i]: counter cleared to 0 (STABLE).
  - s[i]!=btn_level[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s[i]!=btn_level[i] and counter == DEBOUNCE_CYCLES-1: btn_level[i] toggles and counter clears.
  - Any bounce back to the old level restarts the count from 0.
- Latency: btn_raw held steady from cin edge k gives btn_level changing at edge k+1+DEBOUNCE_CYCLES (2 synchroniser cycles, then DEBOUNCE_CYCLES-1 counted cycles).
- press_pulse[i] is registered:
  - asserts in the same cycle btn_level[i] first reads 1, for exactly one cycle;
  - releases (1->0) produce no pulse.
- press_valid, press_idx and press_multi are registered in the same cycle as press_pulse and derived from the same next-state vector.
  - Priority: lowest index wins.
  - Example: press_pulse=9'b000100100 gives idx=2, multi=1.
- Holding a button produces exactly one pulse. A new pulse requires a debounced release followed by a debounced press.
- Channels are fully independent. Simultaneous acceptance on several channels is allowed and reported as above.
- Reset mid-count: counters are discarded. After release, a held button is re-debounced from 0 and generates a fresh press_pulse.

Optional Feature:
- Macro BTN_LOCKOUT_EN.
- Defined:
  - After any press_valid, a CNT-sized lockout counter (width ceil(log2(LOCKOUT_CYCLES))) loads LOCKOUT_CYCLES-1.
  - While it is nonzero, press_pulse, press_valid, press_idx and press_multi are forced to 0. btn_level continues to update.
  - Presses accepted during lockout are dropped, not queued.
  - The counter decrements to 0, and reporting resumes on the next cycle after it reaches 0.
  - Reset clears the lockout.
  - Purpose: prevents a single whack from scoring twice.
- Undefined: no lockout logic and no counter; every accepted press is reported.

Test Plan:
- (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 throughout.) Raise btn_raw[3] at edge 10 and hold -> btn_level[3]=1 at edge 15; press_pulse=9'h008, press_valid=1, press_idx=3 for one cycle only; no further pulse while held.
- Toggle btn_raw[0] every 2 cycles for 40 cycles -> btn_level[0] stays 0 and no press_pulse; then hold it high -> accepted 5 edges after the hold begins.
- Raise btn_raw[2] and btn_raw[5] on the same edge -> press_pulse=9'h024, press_idx=2, press_multi=1 for one cycle.
- Press and hold btn[7] until accepted, then release and hold low -> btn_level[7] falls 5 edges after release with no pulse; a re-press yields a second pulse with idx=7.
- Assert reset while btn[1] counter=2 -> all outputs 0 immediately. Release reset with btn[1] still high -> press accepted 5 edges after release, single pulse, idx=1.
- With BTN_LOCKOUT_EN, LOCKOUT_CYCLES=20: press btn[4], then press btn[6] 10 cycles later -> only the idx=4 report; a btn[6] press accepted after lockout expiry is reported with idx=6.
